// File: rtl/apb_lint_pkg.sv
// Shared types for the APB-to-LINT bridge: FSM state encoding and LINT
// write-enable polarity (active-low).
package apb_lint_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      REQ         = 2'd1,
      WAIT_RVALID = 2'd2,
      DONE        = 2'd3
   } apb2lint_state_e;

   localparam logic WEN_WRITE = 1'b0;
   localparam logic WEN_READ  = 1'b1;

endpackage

// File: rtl/apb_2_lint.sv
// APB3 slave to LINT/TCDM master bridge: each APB transfer becomes exactly one
// LINT req/gnt + r_valid transaction, with PREADY held low until the response lands.
module apb_2_lint
   import apb_lint_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 10,
   parameter int AUX_WIDTH  = 8,
   parameter int ID_VALUE   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PWRITE,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  data_req_o,
   output logic [ADDR_WIDTH-1:0] data_add_o,
   output logic                  data_wen_o,
   output logic [DATA_WIDTH-1:0] data_wdata_o,
   output logic [BE_WIDTH-1:0]   data_be_o,
   output logic [AUX_WIDTH-1:0]  data_aux_o,
   output logic [ID_WIDTH-1:0]   data_ID_o,
   input  logic                  data_gnt_i,
   input  logic                  data_r_valid_i,
   input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
   input  logic                  data_r_opc_i,
   input  logic [AUX_WIDTH-1:0]  data_r_aux_i,
   input  logic [ID_WIDTH-1:0]   data_r_ID_i
);

   apb2lint_state_e state;
   logic            aborted;
   logic            resp_now;
   logic            resp_keep;
   logic            unused_inputs;

   assign data_be_o  = '1;
   assign data_aux_o = '0;
   assign data_ID_o  = ID_WIDTH'(ID_VALUE);

   // Only one transaction is ever outstanding, so the response aux/ID need no check.
   assign unused_inputs = ^{data_r_aux_i, data_r_ID_i};

   // A response counts in WAIT_RVALID, or in REQ when a zero-latency slave
   // returns it together with the grant.
   assign resp_now  = data_r_valid_i &
                      ((state == WAIT_RVALID) | ((state == REQ) & data_gnt_i));
   assign resp_keep = resp_now & PSEL & ~aborted;

   // Bridge FSM and request register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         data_req_o   <= 1'b0;
         data_add_o   <= '0;
         data_wdata_o <= '0;
         data_wen_o   <= WEN_READ;
         aborted      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (PSEL) begin
                  data_add_o   <= PADDR;
                  data_wdata_o <= PWDATA;
                  data_wen_o   <= ~PWRITE;
                  data_req_o   <= 1'b1;
                  aborted      <= 1'b0;
                  state        <= REQ;
               end
            end
            REQ: begin
               // A master that walks away still gets its request completed on LINT.
               if (!PSEL) begin
                  aborted <= 1'b1;
               end
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  if (data_r_valid_i) begin
                     state <= resp_keep ? DONE : IDLE;
                  end else begin
                     state <= WAIT_RVALID;
                  end
               end
            end
            WAIT_RVALID: begin
               if (!PSEL) begin
                  aborted <= 1'b1;
               end
               if (data_r_valid_i) begin
                  state <= resp_keep ? DONE : IDLE;
               end
            end
            DONE: begin
               if (PSEL && PENABLE) begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               data_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Response register bank: writes leave PRDATA untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end else if (resp_keep) begin
         if (data_wen_o == WEN_READ) begin
            PRDATA <= data_r_rdata_i;
         end
         PSLVERR <= data_r_opc_i;
         PREADY  <= 1'b1;
      end else if ((state == DONE) && PSEL && PENABLE) begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end
   end

endmodule

// File: tb/tb_apb_2_lint.sv
// Self-checking bench for apb_2_lint: directed vector table, randomized
// back-to-back traffic against a memory scoreboard, reset and abort sequences.
module tb_apb_2_lint;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic        data_req_o, data_wen_o, data_gnt_i, data_r_valid_i, data_r_opc_i;
   logic [31:0] data_add_o, data_wdata_o, data_r_rdata_i;
   logic [3:0]  data_be_o;
   logic [7:0]  data_aux_o, data_r_aux_i;
   logic [9:0]  data_ID_o, data_r_ID_i;

   apb_2_lint dut (
      .clk(clk), .rst_n(rst_n),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
      .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_aux_o(data_aux_o),
      .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
      .data_r_rdata_i(data_r_rdata_i), .data_r_opc_i(data_r_opc_i),
      .data_r_aux_i(data_r_aux_i), .data_r_ID_i(data_r_ID_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // ---------------- behavioural LINT slave ----------------
   int          cur_g = 0, cur_r = 1;
   logic        cur_opc = 1'b0;
   logic [31:0] slave_mem [logic [31:0]];
   int          req_count = 0;
   logic [31:0] obs_add, obs_wdata, resp;
   logic        obs_wen, obs_stable, obs_req_after;
   logic [3:0]  obs_be;
   logic [7:0]  obs_aux;
   logic [9:0]  obs_id;
   int          obs_hold;

   initial begin : lint_slave
      data_gnt_i = 1'b0; data_r_valid_i = 1'b0; data_r_rdata_i = 32'h0;
      data_r_opc_i = 1'b0; data_r_aux_i = 8'h0; data_r_ID_i = 10'h0;
      @(posedge clk); #1;
      forever begin
         if (data_req_o === 1'b1) begin
            req_count++;
            obs_add = data_add_o; obs_wdata = data_wdata_o; obs_wen = data_wen_o;
            obs_be = data_be_o; obs_aux = data_aux_o; obs_id = data_ID_o;
            obs_hold = 1; obs_stable = 1'b1;
            for (int k = 0; k < cur_g; k++) begin
               @(posedge clk); #1;
               if (data_req_o !== 1'b1 || data_add_o !== obs_add ||
                   data_wdata_o !== obs_wdata || data_wen_o !== obs_wen)
                  obs_stable = 1'b0;
               if (data_req_o === 1'b1) obs_hold++;
            end
            data_gnt_i = 1'b1;
            if (obs_wen == 1'b0) begin
               slave_mem[obs_add] = obs_wdata;
               resp = 32'h0BAD_F00D;
            end else begin
               resp = slave_mem.exists(obs_add) ? slave_mem[obs_add] : dflt(obs_add);
            end
            if (cur_r == 0) begin
               data_r_valid_i = 1'b1; data_r_rdata_i = resp; data_r_opc_i = cur_opc;
            end
            @(posedge clk); #1;
            obs_req_after = data_req_o;
            data_gnt_i = 1'b0; data_r_valid_i = 1'b0; data_r_opc_i = 1'b0;
            if (cur_r > 0) begin
               for (int k = 1; k < cur_r; k++) begin
                  @(posedge clk); #1;
               end
               data_r_valid_i = 1'b1; data_r_rdata_i = resp; data_r_opc_i = cur_opc;
               @(posedge clk); #1;
               data_r_valid_i = 1'b0; data_r_opc_i = 1'b0;
            end
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   // ---------------- APB master ----------------
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int cyc);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      cyc = -1; rd = 32'h0; err = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      check("req_at_cycle1", data_req_o, 64'd1);
      for (int c = 1; c <= 60; c++) begin
         if (PREADY === 1'b1) begin
            cyc = c; rd = PRDATA; err = PSLVERR;
            break;
         end
         @(posedge clk); #1;
      end
      if (cyc < 0) begin
         total++; bad++;
         $display("FAIL pready_timeout: no PREADY within 60 cycles");
      end
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      check("pready_after_end", PREADY, 64'd0);
      check("pslverr_after_end", PSLVERR, 64'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        do_preload;
      logic [31:0] preload;
      int          g;
      int          r;
      logic        opc;
      int          exp_cyc;
      logic [31:0] exp_prdata;
      logic        exp_err;
   } vec_t;

   vec_t        vecs [5];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] model_prdata, rd, a, wd, exp_rd;
   logic        err, wr, saw_ready;
   int          cyc, base_count, g, r;

   task automatic check_lint_fields(input logic wr_i, input logic [31:0] addr_i,
                                    input logic [31:0] wd_i, input int g_i);
      check("lint_add", obs_add, addr_i);
      check("lint_wen", obs_wen, {63'd0, ~wr_i});
      check("lint_wdata", obs_wdata, wd_i);
      check("lint_be", obs_be, 64'hF);
      check("lint_aux", obs_aux, 64'd0);
      check("lint_id", obs_id, 64'd0);
      check("req_hold_cycles", obs_hold, g_i + 1);
      check("req_stable", obs_stable, 64'd1);
      check("req_drop_after_gnt", obs_req_after, 64'd0);
   endtask

   initial begin : main
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
      rst_n = 1'b0;
      model_prdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", data_req_o, 64'd0);
      check("rst_pready", PREADY, 64'd0);
      check("rst_pslverr", PSLVERR, 64'd0);
      check("rst_prdata", PRDATA, 64'd0);
      check("rst_wen", data_wen_o, 64'd1);
      check("rst_add", data_add_o, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table: PREADY cycle = 2 + gnt delay + r_valid delay.
      vecs[0] = '{wr:1'b0, addr:32'h1C00_0000, wdata:32'h0000_0000, do_preload:1'b1,
                  preload:32'hDEAD_BEEF, g:0, r:1, opc:1'b0, exp_cyc:3,
                  exp_prdata:32'hDEAD_BEEF, exp_err:1'b0};
      vecs[1] = '{wr:1'b1, addr:32'h1C01_0040, wdata:32'h1234_5678, do_preload:1'b0,
                  preload:32'h0, g:5, r:1, opc:1'b0, exp_cyc:8,
                  exp_prdata:32'hDEAD_BEEF, exp_err:1'b0};
      vecs[2] = '{wr:1'b0, addr:32'h1C01_0040, wdata:32'hAAAA_5555, do_preload:1'b0,
                  preload:32'h0, g:2, r:0, opc:1'b0, exp_cyc:4,
                  exp_prdata:32'h1234_5678, exp_err:1'b0};
      vecs[3] = '{wr:1'b0, addr:32'h1C00_0100, wdata:32'h0000_0000, do_preload:1'b1,
                  preload:32'hCAFE_0001, g:1, r:2, opc:1'b1, exp_cyc:5,
                  exp_prdata:32'hCAFE_0001, exp_err:1'b1};
      vecs[4] = '{wr:1'b1, addr:32'h1C00_0100, wdata:32'h0000_0000, do_preload:1'b0,
                  preload:32'h0, g:0, r:0, opc:1'b0, exp_cyc:2,
                  exp_prdata:32'hCAFE_0001, exp_err:1'b0};

      for (int i = 0; i < 5; i++) begin
         if (vecs[i].do_preload) slave_mem[vecs[i].addr] = vecs[i].preload;
         cur_g = vecs[i].g; cur_r = vecs[i].r; cur_opc = vecs[i].opc;
         base_count = req_count;
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, cyc);
         check("vec_cycles", cyc, vecs[i].exp_cyc);
         check("vec_prdata", rd, vecs[i].exp_prdata);
         check("vec_pslverr", err, vecs[i].exp_err);
         check("vec_req_count", req_count - base_count, 64'd1);
         check_lint_fields(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].g);
      end
      model_prdata = 32'hCAFE_0001;

      // Back-to-back random traffic against a memory scoreboard.
      base_count = req_count;
      for (int i = 0; i < 10; i++) begin
         wr = (i % 2 == 0);
         a  = 32'h1C02_0000 + {26'd0, 4'($urandom_range(0, 3)), 2'b00};
         wd = $urandom;
         g  = $urandom_range(0, 3);
         r  = $urandom_range(0, 3);
         cur_g = g; cur_r = r; cur_opc = 1'($urandom_range(0, 1));
         exp_rd = wr ? model_prdata : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
         apb_xfer(wr, a, wd, rd, err, cyc);
         if (wr) ref_mem[a] = wd;
         model_prdata = exp_rd;
         check("rand_cycles", cyc, 2 + g + r);
         check("rand_prdata", rd, exp_rd);
         check("rand_pslverr", err, cur_opc);
         check("rand_lint_wen", obs_wen, {63'd0, ~wr});
         check("rand_lint_add", obs_add, a);
      end
      check("rand_req_count", req_count - base_count, 64'd10);

      // Reset while waiting for r_valid.
      cur_g = 0; cur_r = 4; cur_opc = 1'b0;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h1C00_0200; PWDATA = 32'hFFFF_0000;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_req", data_req_o, 64'd0);
      check("midrst_pready", PREADY, 64'd0);
      check("midrst_pslverr", PSLVERR, 64'd0);
      check("midrst_prdata", PRDATA, 64'd0);
      check("midrst_add", data_add_o, 64'd0);
      check("midrst_wdata", data_wdata_o, 64'd0);
      check("midrst_wen", data_wen_o, 64'd1);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      slave_mem[32'h1C00_0300] = 32'h7777_1234;
      cur_g = 1; cur_r = 1;
      apb_xfer(1'b0, 32'h1C00_0300, 32'h0, rd, err, cyc);
      check("postrst_cycles", cyc, 64'd4);
      check("postrst_prdata", rd, 32'h7777_1234);
      check("postrst_pslverr", err, 64'd0);
      model_prdata = 32'h7777_1234;

      // Master drops PSEL mid-transfer: LINT side completes, APB side sees nothing.
      slave_mem[32'h1C00_0400] = 32'h1111_2222;
      cur_g = 2; cur_r = 1;
      base_count = req_count;
      saw_ready = 1'b0;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h1C00_0400; PWDATA = 32'h0;
      @(posedge clk); #1;
      PSEL = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (PREADY === 1'b1) saw_ready = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_no_pready", saw_ready, 64'd0);
      check("abort_req_count", req_count - base_count, 64'd1);
      check("abort_prdata_kept", PRDATA, model_prdata);
      cur_g = 0; cur_r = 0;
      apb_xfer(1'b0, 32'h1C00_0400, 32'h0, rd, err, cyc);
      check("after_abort_cycles", cyc, 64'd2);
      check("after_abort_prdata", rd, 32'h1111_2222);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
